// File: rtl/traceback_walker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// traceback_walker
//   Needleman-Wunsch traceback engine. Walks the direction matrix from
//   (N_ROWS,N_COLS) back to (0,0), reading one direction symbol per interior
//   cell from an external RAM with a fixed read latency, and streaming one
//   alignment step per cell over a valid/ready interface. Cells on row 0 or
//   column 0 are forced to LEFT/UP without touching the RAM. A non one-hot
//   symbol from the RAM aborts the walk and raises a sticky error flag.
//
//   Optional feature macro: TB_STEP_COUNT_EN adds the step_cnt output.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start                   start a walk (sampled only while idle)
//   dir_re                  direction-RAM read strobe, one-cycle pulse
//   dir_addr_i/dir_addr_j   RAM address (i-1, j-1); hold value between reads
//   dir_rdata               direction symbol, valid RD_LAT cycles after dir_re
//   step_valid/step_ready   output step handshake
//   step_sym                DIAG=3'b001, UP=3'b010, LEFT=3'b100
//   i_pos, j_pos            current matrix position
//   busy                    walk in progress
//   done                    one-cycle pulse at end of walk
//   err                     sticky illegal-symbol flag, cleared on next start
//   step_cnt                (TB_STEP_COUNT_EN) accepted steps of current walk
// -----------------------------------------------------------------------------
module traceback_walker #(
  parameter  int N_ROWS = 128,
  parameter  int N_COLS = 128,
  parameter  int RD_LAT = 2,
  localparam int IW     = $clog2(N_ROWS + 1),
  localparam int JW     = $clog2(N_COLS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          dir_re,
  output logic [IW-1:0] dir_addr_i,
  output logic [JW-1:0] dir_addr_j,
  input  logic [2:0]    dir_rdata,
  output logic          step_valid,
  input  logic          step_ready,
  output logic [2:0]    step_sym,
  output logic [IW-1:0] i_pos,
  output logic [JW-1:0] j_pos,
  output logic          busy,
  output logic          done,
`ifdef TB_STEP_COUNT_EN
  output logic [IW:0]   step_cnt,
`endif
  output logic          err
);

  localparam logic [2:0] SYM_DIAG = 3'b001;
  localparam logic [2:0] SYM_UP   = 3'b010;
  localparam logic [2:0] SYM_LEFT = 3'b100;
  localparam int         LW       = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, FIN} state_t;

  state_t        state, state_nxt;
  logic [2:0]    sym_q;
  logic [LW-1:0] lat_cnt;
  logic [IW-1:0] addr_i_q;
  logic [JW-1:0] addr_j_q;

  logic at_row0, at_col0, rd_issue, lat_done, sym_legal, accept, step_fire;

  assign at_row0   = (i_pos == '0);
  assign at_col0   = (j_pos == '0);
  assign rd_issue  = (state == ISSUE) && !at_row0 && !at_col0;
  assign lat_done  = (lat_cnt == LW'(RD_LAT));
  assign sym_legal = (dir_rdata == SYM_DIAG) || (dir_rdata == SYM_UP) ||
                     (dir_rdata == SYM_LEFT);
  assign accept    = (state == IDLE) && start;
  assign step_fire = (state == EMIT) && step_ready;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: default assignment first, so no path through the case leaves
  // state_nxt unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: begin
        if (at_row0 && at_col0) state_nxt = FIN;
        else if (rd_issue)      state_nxt = WAIT;
        else                    state_nxt = EMIT;
      end
      WAIT:  if (lat_done) state_nxt = sym_legal ? EMIT : FIN;
      EMIT:  if (step_ready) state_nxt = ISSUE;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. The read address is presented combinationally in the issuing
  // cycle and otherwise holds the last address actually read.
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == FIN);
    step_valid = (state == EMIT);
    step_sym   = (state == EMIT) ? sym_q : 3'b000;
    dir_re     = rd_issue;
    dir_addr_i = rd_issue ? (i_pos - IW'(1)) : addr_i_q;
    dir_addr_j = rd_issue ? (j_pos - JW'(1)) : addr_j_q;
  end

  // Position, symbol, latency counter and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_pos    <= IW'(N_ROWS);
      j_pos    <= JW'(N_COLS);
      sym_q    <= 3'b000;
      lat_cnt  <= '0;
      addr_i_q <= '0;
      addr_j_q <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        i_pos <= IW'(N_ROWS);
        j_pos <= JW'(N_COLS);
        err   <= 1'b0;
      end
      if (state == ISSUE) begin
        if (rd_issue) begin
          addr_i_q <= i_pos - IW'(1);
          addr_j_q <= j_pos - JW'(1);
          lat_cnt  <= LW'(1);
        end else if (at_row0 && !at_col0) begin
          sym_q <= SYM_LEFT;
        end else if (at_col0 && !at_row0) begin
          sym_q <= SYM_UP;
        end
      end
      // Data is captured in the RD_LAT-th cycle after the strobe.
      if (state == WAIT) begin
        if (lat_done) begin
          if (sym_legal) sym_q <= dir_rdata;
          else           err   <= 1'b1;
        end else begin
          lat_cnt <= lat_cnt + LW'(1);
        end
      end
      // Interior cells have i,j > 0 and boundary cells only get the move
      // along their free axis, so the decrements below never underflow.
      if (step_fire) begin
        if (sym_q != SYM_LEFT) i_pos <= i_pos - IW'(1);
        if (sym_q != SYM_UP)   j_pos <= j_pos - JW'(1);
      end
    end
  end

`ifdef TB_STEP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         step_cnt <= '0;
    else if (accept)    step_cnt <= '0;
    else if (step_fire) step_cnt <= step_cnt + (IW+1)'(1);
  end
`endif

endmodule
